// File: rtl/core_pkg.sv
// core_pkg: shared decode types for the RV32I pipeline.
//   inst_type_e / alu_op_e / wb_sel_e / arg1_sel_e : control-word field encodings
//   ctrl_t   : packed 20-bit control word, CtrlW derived from it
//   Op*      : major opcode constants, InstEbreak: the one accepted SYSTEM encoding
package core_pkg;

  typedef enum logic [3:0] {
    ItLoad   = 4'd0,
    ItImm    = 4'd1,
    ItStore  = 4'd2,
    ItReg    = 4'd3,
    ItLui    = 4'd4,
    ItAuipc  = 4'd5,
    ItBranch = 4'd6,
    ItJalr   = 4'd7,
    ItJal    = 4'd8
  } inst_type_e;

  typedef enum logic [4:0] {
    AluAdd    = 5'd0,
    AluSub    = 5'd1,
    AluOr     = 5'd2,
    AluAnd    = 5'd3,
    AluXor    = 5'd4,
    AluSll    = 5'd5,
    AluSrl    = 5'd6,
    AluSra    = 5'd7,
    AluSlt    = 5'd8,
    AluSltu   = 5'd9,
    AluMul    = 5'd10,
    AluMulh   = 5'd11,
    AluMulhsu = 5'd12,
    AluMulhu  = 5'd13,
    AluDiv    = 5'd14,
    AluDivu   = 5'd15,
    AluRem    = 5'd16,
    AluRemu   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    WbMem = 2'd0,
    WbAlu = 2'd1,
    WbPc4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    Arg1Rs1  = 2'd0,
    Arg1Pc   = 2'd1,
    Arg1Zero = 2'd2
  } arg1_sel_e;

  typedef struct packed {
    inst_type_e inst_type;    // [19:16]
    logic       dmem_we;      // [15]
    logic       jump;         // [14]
    wb_sel_e    wb_sel;       // [13:12]
    arg1_sel_e  arg1_sel;     // [11:10]
    logic       arg2_sel;     // [9]   1: imm, 0: rs2
    logic       rf_we;        // [8]
    alu_op_e    alu_op;       // [7:3]
    logic [2:0] branch_type;  // [2:0] funct3 of a branch
  } ctrl_t;

  localparam int unsigned CtrlW = $bits(ctrl_t);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [31:0] InstEbreak = 32'h0010_0073;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch->decode and decode->execute handshake bundle.
//   in_valid/in_ready/in_inst/in_pc             : fetch side
//   out_valid/out_ready/out_ctrl/out_inst/out_pc/out_illegal : execute side
// Modports: slave is the decode stage, master is whoever drives fetch and
// consumes the execute side (pipeline glue or a bench).
interface decode_stage_if #(
  parameter int unsigned PC_W = 32
);
  import core_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  ctrl_t           out_ctrl;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_inst, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_inst, out_pc, out_illegal
  );

endinterface

// File: rtl/decode_comb.sv
// decode_comb: pure combinational RV32I instruction -> control word mapping.
//   i_inst      : raw 32-bit instruction
//   o_ctrl      : control word, all-zero for illegal encodings and ebreak
//   o_illegal   : encoding is illegal or unsupported (fence, ecall, csr, ...)
//   o_is_ebreak : instruction is exactly ebreak
// Build option: DECODE_RV32M_EN makes OP with funct7=0000001 (M extension) legal.
module decode_comb
  import core_pkg::*;
(
  input  logic [31:0] i_inst,
  output ctrl_t       o_ctrl,
  output logic        o_illegal,
  output logic        o_is_ebreak
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  alu_op_e    w_f3_alu;
  ctrl_t      w_ctrl;
  logic       w_legal;
  logic       w_is_ebreak;

  assign w_opcode = i_inst[6:0];
  assign w_funct3 = i_inst[14:12];
  assign w_funct7 = i_inst[31:25];

  // funct3 -> ALU op, common to OP and OP-IMM
  always_comb begin
    case (w_funct3)
      3'b000:  w_f3_alu = AluAdd;
      3'b001:  w_f3_alu = AluSll;
      3'b010:  w_f3_alu = AluSlt;
      3'b011:  w_f3_alu = AluSltu;
      3'b100:  w_f3_alu = AluXor;
      3'b101:  w_f3_alu = AluSrl;
      3'b110:  w_f3_alu = AluOr;
      default: w_f3_alu = AluAnd;
    endcase
  end

  always_comb begin
    w_ctrl             = '0;
    w_ctrl.wb_sel      = WbAlu;
    w_ctrl.arg1_sel    = Arg1Rs1;
    w_ctrl.arg2_sel    = 1'b1;
    w_ctrl.rf_we       = 1'b1;
    w_ctrl.alu_op      = AluAdd;
    w_legal            = 1'b0;
    w_is_ebreak        = 1'b0;
    if (i_inst[1:0] == 2'b11) begin
      case (w_opcode)
        OpLoad: begin
          w_ctrl.inst_type = ItLoad;
          w_ctrl.wb_sel    = WbMem;
          w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
        end
        OpImm: begin
          w_ctrl.inst_type = ItImm;
          w_ctrl.alu_op    = w_f3_alu;
          case (w_funct3)
            3'b001: w_legal = (w_funct7 == 7'b0000000);
            3'b101: begin
              w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
              if (w_funct7[5]) w_ctrl.alu_op = AluSra;
            end
            default: w_legal = 1'b1;
          endcase
        end
        OpStore: begin
          w_ctrl.inst_type = ItStore;
          w_ctrl.dmem_we   = 1'b1;
          w_ctrl.rf_we     = 1'b0;
          w_ctrl.wb_sel    = WbMem;
          w_legal = !w_funct3[2] && (w_funct3[1:0] != 2'b11);
        end
        OpReg: begin
          w_ctrl.inst_type = ItReg;
          w_ctrl.arg2_sel  = 1'b0;
          if (w_funct7 == 7'b0000000) begin
            w_legal       = 1'b1;
            w_ctrl.alu_op = w_f3_alu;
          end else if ((w_funct7 == 7'b0100000) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
            w_legal       = 1'b1;
            w_ctrl.alu_op = w_funct3[2] ? AluSra : AluSub;
          end
`ifdef DECODE_RV32M_EN
          else if (w_funct7 == 7'b0000001) begin
            w_legal       = 1'b1;
            w_ctrl.alu_op = alu_op_e'(5'd10 + {2'b00, w_funct3});
          end
`endif
        end
        OpLui: begin
          w_ctrl.inst_type = ItLui;
          w_ctrl.arg1_sel  = Arg1Zero;
          w_legal          = 1'b1;
        end
        OpAuipc: begin
          w_ctrl.inst_type = ItAuipc;
          w_ctrl.arg1_sel  = Arg1Pc;
          w_legal          = 1'b1;
        end
        OpBranch: begin
          // Only operands and condition here; taken/not-taken is resolved in execute.
          w_ctrl.inst_type   = ItBranch;
          w_ctrl.arg2_sel    = 1'b0;
          w_ctrl.rf_we       = 1'b0;
          w_ctrl.wb_sel      = WbMem;
          w_ctrl.alu_op      = AluSub;
          w_ctrl.branch_type = w_funct3;
          w_legal            = (w_funct3[2:1] != 2'b01);
        end
        OpJalr: begin
          w_ctrl.inst_type = ItJalr;
          w_ctrl.jump      = 1'b1;
          w_ctrl.wb_sel    = WbPc4;
          w_legal          = (w_funct3 == 3'b000);
        end
        OpJal: begin
          w_ctrl.inst_type = ItJal;
          w_ctrl.jump      = 1'b1;
          w_ctrl.wb_sel    = WbPc4;
          w_ctrl.arg1_sel  = Arg1Pc;
          w_legal          = 1'b1;
        end
        OpSystem: begin
          // ebreak is the only SYSTEM encoding handled; ecall/csr* are unsupported
          w_is_ebreak = (i_inst == InstEbreak);
          w_legal     = w_is_ebreak;
        end
        default: w_legal = 1'b0;  // includes OpFence
      endcase
    end
    if (!w_legal || w_is_ebreak) w_ctrl = '0;
  end

  assign o_ctrl      = w_ctrl;
  assign o_illegal   = !w_legal;
  assign o_is_ebreak = w_is_ebreak;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with ebreak drain/halt.
//   i_clk    : clock
//   i_rst    : synchronous active-high reset
//   i_flush  : squash the held entry and any pending drain (ignored once halted)
//   io_bus   : decode_stage_if.slave, fetch handshake in, control word out
//   o_halt   : sticky, set DRAIN_CYCLES cycles after an ebreak is accepted
// Parameters: PC_W (must match io_bus), DRAIN_CYCLES in 1..255.
// Build option: DECODE_RV32M_EN enables M-extension decode in decode_comb.
module decode_stage
  import core_pkg::*;
#(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  decode_stage_if.slave io_bus,
  output logic          o_halt
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  localparam logic [7:0] DrainInit = 8'(DRAIN_CYCLES - 1);

  state_e          r_state, w_state_d;
  logic [7:0]      r_cnt, w_cnt_d;
  logic            r_out_valid;
  ctrl_t           r_out_ctrl;
  logic [31:0]     r_out_inst;
  logic [PC_W-1:0] r_out_pc;
  logic            r_out_illegal;

  ctrl_t           w_dec_ctrl;
  logic            w_dec_illegal;
  logic            w_dec_ebreak;
  logic            w_in_ready;
  logic            w_halt;
  logic            w_accept;
  logic            w_flush_eff;

  decode_comb u_decode_comb (
    .i_inst      (io_bus.in_inst),
    .o_ctrl      (w_dec_ctrl),
    .o_illegal   (w_dec_illegal),
    .o_is_ebreak (w_dec_ebreak)
  );

  assign w_accept    = io_bus.in_valid && w_in_ready;
  // A halted core only leaves via reset, so flush is ignored there.
  assign w_flush_eff = i_flush && (r_state != StHalted);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next state
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StRun: begin
        if (!i_flush && w_accept && w_dec_ebreak) begin
          w_state_d = StDrain;
          w_cnt_d   = DrainInit;
        end
      end
      StDrain: begin
        if (i_flush) begin
          // ebreak was on a wrong path
          w_state_d = StRun;
          w_cnt_d   = 8'd0;
        end else if (r_cnt == 8'd0) begin
          w_state_d = StHalted;
        end else begin
          w_cnt_d = r_cnt - 8'd1;
        end
      end
      StHalted: w_state_d = StHalted;
      default:  w_state_d = StRun;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_in_ready = 1'b0;
    w_halt     = 1'b0;
    case (r_state)
      StRun:    w_in_ready = !r_out_valid || io_bus.out_ready;
      StHalted: w_halt     = 1'b1;
      default:  ;
    endcase
  end

  // Output entry; a load with out_ready high replaces the leaving entry on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid   <= 1'b0;
      r_out_ctrl    <= '0;
      r_out_inst    <= '0;
      r_out_pc      <= '0;
      r_out_illegal <= 1'b0;
    end else if (w_flush_eff) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_out_ctrl    <= w_dec_ctrl;
      r_out_inst    <= io_bus.in_inst;
      r_out_pc      <= io_bus.in_pc;
      r_out_illegal <= w_dec_illegal;
    end else if (io_bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready    = w_in_ready;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.out_ctrl    = r_out_ctrl;
  assign io_bus.out_inst    = r_out_inst;
  assign io_bus.out_pc      = r_out_pc;
  assign io_bus.out_illegal = r_out_illegal;
  assign o_halt             = w_halt;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with a reference model that
// predicts every output each cycle, plus hand-computed literal expectations.
module tb_decode_stage;

  localparam int unsigned PcW   = 32;
  localparam int unsigned Drain = 4;
`ifdef DECODE_RV32M_EN
  localparam bit MEn = 1'b1;
`else
  localparam bit MEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic halt;

  always #5 clk = ~clk;

  decode_stage_if #(.PC_W(PcW)) bus ();

  decode_stage #(
    .PC_W         (PcW),
    .DRAIN_CYCLES (Drain)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .io_bus  (bus),
    .o_halt  (halt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // funct3 -> alu_op for OP / OP-IMM
  int f3_alu [8] = '{0, 5, 8, 9, 4, 6, 2, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decoder: field values straight from the instruction set rules.
  function automatic void model_decode(input logic [31:0] inst, output logic [19:0] ctrl,
                                       output bit ill, output bit eb);
    int op, f3, f7, ty, we, jmp, wb, a1, a2, rf, alu, bt;
    bit ok;
    op = int'(inst[6:0]);
    f3 = int'(inst[14:12]);
    f7 = int'(inst[31:25]);
    ok = 1; eb = 0;
    ty = 0; we = 0; jmp = 0; wb = 1; a1 = 0; a2 = 1; rf = 1; alu = 0; bt = 0;
    if (inst[1:0] != 2'b11) ok = 0;
    else begin
      case (op)
        'h03: begin ty = 0; wb = 0; ok = f3 inside {0, 1, 2, 4, 5}; end
        'h13: begin
          ty = 1; alu = f3_alu[f3];
          if (f3 == 1) ok = (f7 == 0);
          if (f3 == 5) begin ok = (f7 == 0) || (f7 == 32); if (f7 == 32) alu = 7; end
        end
        'h23: begin ty = 2; we = 1; rf = 0; wb = 0; ok = (f3 <= 2); end
        'h33: begin
          ty = 3; a2 = 0;
          if (f7 == 0) alu = f3_alu[f3];
          else if (f7 == 32 && f3 == 0) alu = 1;
          else if (f7 == 32 && f3 == 5) alu = 7;
          else if (f7 == 1 && MEn) alu = 10 + f3;
          else ok = 0;
        end
        'h37: begin ty = 4; a1 = 2; end
        'h17: begin ty = 5; a1 = 1; end
        'h63: begin ty = 6; a2 = 0; rf = 0; wb = 0; alu = 1; bt = f3; ok = !(f3 inside {2, 3}); end
        'h67: begin ty = 7; jmp = 1; wb = 2; ok = (f3 == 0); end
        'h6f: begin ty = 8; jmp = 1; wb = 2; a1 = 1; end
        'h73: begin eb = (inst == 32'h0010_0073); ok = eb; end
        default: ok = 0;
      endcase
    end
    ill = !ok;
    if (!ok || eb) ctrl = '0;
    else ctrl = {4'(ty), 1'(we), 1'(jmp), 2'(wb), 2'(a1), 1'(a2), 1'(rf), 5'(alu), 3'(bt)};
  endfunction

  // Model state: out entry, plus an ebreak deadline expressed in edge numbers.
  bit          m_known = 0;
  bit          m_valid = 0;
  logic [19:0] m_ctrl  = '0;
  logic [31:0] m_inst  = '0;
  logic [31:0] m_pc    = '0;
  bit          m_ill   = 0;
  bit          m_pend  = 0;
  int          m_halt_at = 0;
  int          m_edge  = 0;

  // Compare at negedge, then advance the model across the coming posedge.
  always @(negedge clk) begin
    bit halted, exp_rdy, accept, ill, eb;
    logic [19:0] c;
    halted  = m_pend && (m_edge >= m_halt_at);
    exp_rdy = !m_pend && (!m_valid || bus.out_ready);
    if (m_known) begin
      chk("in_ready",    64'(bus.in_ready),    64'(exp_rdy));
      chk("halt",        64'(halt),            64'(halted));
      chk("out_valid",   64'(bus.out_valid),   64'(m_valid));
      chk("out_ctrl",    64'(bus.out_ctrl),    64'(m_ctrl));
      chk("out_inst",    64'(bus.out_inst),    64'(m_inst));
      chk("out_pc",      64'(bus.out_pc),      64'(m_pc));
      chk("out_illegal", 64'(bus.out_illegal), 64'(m_ill));
    end
    m_edge++;
    if (rst) begin
      m_known = 1; m_valid = 0; m_ctrl = '0; m_inst = '0; m_pc = '0; m_ill = 0; m_pend = 0;
    end else begin
      accept = bus.in_valid && exp_rdy;
      if (flush && !halted) begin
        m_valid = 0;
        m_pend  = 0;
      end else if (accept) begin
        model_decode(bus.in_inst, c, ill, eb);
        m_valid = 1; m_ctrl = c; m_ill = ill; m_inst = bus.in_inst; m_pc = bus.in_pc;
        if (eb) begin m_pend = 1; m_halt_at = m_edge + int'(Drain); end
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] Addi   = 32'h0050_0093;
  localparam logic [31:0] Sub    = 32'h4020_8133;
  localparam logic [31:0] Mul    = 32'h0220_8133;
  localparam logic [31:0] Ebreak = 32'h0010_0073;
  localparam logic [31:0] InstA  = 32'h00A0_0113;
  localparam logic [31:0] InstB  = 32'h0020_C1B3;

  logic [31:0] illegal_vec [3] = '{32'h0000_0000, 32'h0000_000F, 32'h0000_0073};
  logic [31:0] mix_vec [14] = '{
    32'h0000_A183, 32'h0020_A023, 32'h0020_8463, 32'h0020_C463, 32'h0000_80E7,
    32'h0080_00EF, 32'h1234_50B7, 32'h0000_1097, 32'h4010_D093, 32'h4010_9093,
    32'h0020_B1B3, 32'h4020_D1B3, 32'h0000_B183, 32'h3000_1073
  };

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_halt",      64'(halt),          64'd0);
    chk("rst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
    chk("rst_out_inst",  64'(bus.out_inst),  64'd0);
    chk("rst_out_pc",    64'(bus.out_pc),    64'd0);
    chk("rst_illegal",   64'(bus.out_illegal), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    rst = 1'b0;

    // Back-to-back addi, sub
    step(1, Addi, 32'h100, 1, 0);
    chk("addi_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_ctrl",  64'(bus.out_ctrl),  64'h11300);
    chk("addi_alu",   64'(bus.out_ctrl.alu_op), 64'd0);
    chk("addi_arg2",  64'(bus.out_ctrl.arg2_sel), 64'd1);
    step(1, Sub, 32'h104, 1, 0);
    chk("sub_valid", 64'(bus.out_valid), 64'd1);
    chk("sub_ctrl",  64'(bus.out_ctrl),  64'h31108);
    chk("sub_alu",   64'(bus.out_ctrl.alu_op), 64'd1);
    chk("sub_arg2",  64'(bus.out_ctrl.arg2_sel), 64'd0);
    step(0, 0, 0, 1, 0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // Stall with out_ready low
    step(1, InstA, 32'h200, 0, 0);
    chk("stall_load", 64'(bus.out_inst), 64'(InstA));
    for (int i = 0; i < 3; i++) begin
      step(1, InstB, 32'h204, 0, 0);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("stall_hold_inst", 64'(bus.out_inst), 64'(InstA));
      chk("stall_hold_pc", 64'(bus.out_pc), 64'h200);
    end
    step(1, InstB, 32'h204, 1, 0);
    chk("release_inst", 64'(bus.out_inst), 64'(InstB));
    step(0, 0, 0, 1, 0);
    chk("release_once", 64'(bus.out_valid), 64'd0);

    // Illegal encodings
    for (int i = 0; i < 3; i++) begin
      step(1, illegal_vec[i], 32'h300 + 4 * i, 1, 0);
      chk("illegal_flag", 64'(bus.out_illegal), 64'd1);
      chk("illegal_ctrl", 64'(bus.out_ctrl), 64'd0);
    end

    // M extension
    step(1, Mul, 32'h320, 1, 0);
    chk("mul_illegal", 64'(bus.out_illegal), MEn ? 64'd0 : 64'd1);
    chk("mul_ctrl", 64'(bus.out_ctrl), MEn ? 64'h31150 : 64'd0);

    // Mixed stream, model-checked; jal pinned by hand
    for (int i = 0; i < 14; i++) begin
      step(1, mix_vec[i], 32'h400 + 4 * i, 1, 0);
      if (i == 5) chk("jal_ctrl", 64'(bus.out_ctrl), 64'h86700);
    end

    // Flush beats a simultaneous accept; flush drops a stalled entry
    step(1, Addi, 32'h500, 1, 1);
    chk("flush_accept", 64'(bus.out_valid), 64'd0);
    step(1, Addi, 32'h504, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("flush_stalled", 64'(bus.out_valid), 64'd0);
    step(0, 0, 0, 1, 0);

    // ebreak -> halt after Drain cycles, flush ignored once halted
    step(1, Ebreak, 32'h600, 1, 0);
    chk("ebreak_in_ready", 64'(bus.in_ready), 64'd0);
    chk("ebreak_ctrl", 64'(bus.out_ctrl), 64'd0);
    chk("ebreak_legal", 64'(bus.out_illegal), 64'd0);
    for (int k = 1; k <= 7; k++) begin
      step(1, Addi, 32'h604, 1, k >= 5);
      chk("halt_timing", 64'(halt), (k >= 4) ? 64'd1 : 64'd0);
    end
    rst = 1'b1;
    step(0, 0, 0, 1, 0);
    rst = 1'b0;
    chk("halt_rst", 64'(halt), 64'd0);
    chk("halt_rst_ready", 64'(bus.in_ready), 64'd1);

    // ebreak, flush two cycles later
    step(1, Ebreak, 32'h700, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("flush_drain_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 1, 0);
      chk("flush_drain_nohalt", 64'(halt), 64'd0);
    end
    step(1, Addi, 32'h710, 1, 0);
    chk("flush_drain_run", 64'(bus.out_valid), 64'd1);

    // Reset during drain
    step(1, Ebreak, 32'h800, 1, 0);
    step(0, 0, 0, 1, 0);
    rst = 1'b1;
    step(0, 0, 0, 1, 0);
    rst = 1'b0;
    chk("rst_drain_ready", 64'(bus.in_ready), 64'd1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0);
    chk("rst_drain_nohalt", 64'(halt), 64'd0);

    step(0, 0, 0, 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I decode stage that sits between the fetch and execute stages of the pipelined core and replaces the purely combinational decoder. It accepts instructions over a valid/ready handshake and produces a fully defined control word one cycle later. Illegal encodings are flagged instead of driving X. A drain/halt state machine handles `ebreak` in synthesisable form, and branch-taken selection moves to execute.

## Interface
- `PC_W`, default 32: width of the PC carried alongside the instruction.
- `DRAIN_CYCLES`, default 4: cycles to wait after an accepted `ebreak` before asserting `halt`; legal range 1 to 255.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `flush` input, 1 bit: squash the held entry and any pending drain.
- `in_valid` input, 1 bit: fetch presents an instruction.
- `in_ready` output, 1 bit: stage can accept.
- `in_inst` input, 32 bits: raw instruction.
- `in_pc` input, `PC_W` bits: instruction PC.
- `out_valid` output, 1 bit: registered decode result present.
- `out_ready` input, 1 bit: execute accepts.
- `out_ctrl` output, 20 bits: control word (layout below).
- `out_inst` output, 32 bits: registered instruction.
- `out_pc` output, `PC_W` bits: registered PC.
- `out_illegal` output, 1 bit: entry is an illegal or unsupported encoding.
- `halt` output, 1 bit: sticky, set when the drain completes.

## Operation
- Control word layout:
  - [19:16] `inst_type`: 0 load, 1 imm, 2 store, 3 reg, 4 lui, 5 auipc, 6 branch, 7 jalr, 8 jal.
  - [15] `dmem_we`.
  - [14] `jump`: jal/jalr only. Branch-taken is resolved in execute.
  - [13:12] `wb_sel`: 0 mem, 1 alu, 2 pc+4.
  - [11:10] `arg1_sel`: 0 rs1, 1 pc, 2 zero.
  - [9] `arg2_sel`: 1 imm, 0 rs2.
  - [8] `rf_we`.
  - [7:3] `alu_op`: 0 add, 1 sub, 2 or, 3 and, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10–17 M-extension.
  - [2:0] `branch_type`: funct3.
- Decode field rules are unchanged from the current RV32I decoder for all legal opcodes.
- Illegal conditions:
  - `inst[1:0]` is not 2'b11.
  - Opcode is unknown.
  - Opcode is FENCE or ECALL.
  - funct7/funct3 combination is not defined.
- For an illegal instruction: `out_illegal` = 1 and `out_ctrl` = 0, so `rf_we` = 0 and `dmem_we` = 0. No X is ever driven.
- Registered state: a single-entry register with `out_valid` set.
  - Load condition: `in_valid && in_ready`.
  - `in_ready` = (state == RUN) && (!`out_valid` || `out_ready`).
- State machine:
  - **RUN**: an accepted `ebreak` is registered as a legal entry with `out_ctrl` = 0, and the state moves to DRAIN with the counter loaded to `DRAIN_CYCLES`-1.
  - **DRAIN**: `in_ready` = 0. The counter decrements each cycle. At 0 the state moves to HALTED.
  - **HALTED**: `halt` = 1 and `in_ready` = 0. Only `rst` exits this state.
- `flush` has priority over everything except `rst`:
  - Next cycle `out_valid` = 0.
  - In DRAIN, the state returns to RUN because the `ebreak` was on a wrong path.
  - In HALTED, `flush` has no effect.
  - When `flush` and an accept occur in the same cycle, the accept is discarded.
- Simultaneous `out_ready` and load: the old entry leaves and the new entry is captured in the same edge.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle while `out_ready` is held high.
- Reset values, taken on the first edge with `rst` = 1:
  - state = RUN, counter = 0.
  - `out_valid` = 0, `out_illegal` = 0, `halt` = 0.
  - `out_ctrl` = 0, `out_inst` = 0, `out_pc` = 0.
- `in_ready` is combinational from the state, `out_valid` and `out_ready`. No other combinational path runs from input to output.
- Holding `out_ready` low freezes all `out_*` signals stably.
- `halt` rises exactly `DRAIN_CYCLES` cycles after the `ebreak` accept edge.
- `rst` during DRAIN or HALTED returns the block to RUN on that edge.

## Configuration
- Macro: `DECODE_RV32M_EN`.
- **Defined**: opcode 0110011 with funct7 = 0000001 decodes funct3 0–7 to `alu_op` 10–17 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu), with `inst_type` 3 and `rf_we` 1.
- **Undefined**: those same encodings are illegal.

## Structure
- Shared package `core_pkg` holds:
  - the `inst_type`, `alu_op`, `wb_sel` and `arg1_sel` enums;
  - the control-word packed struct, so its width is derived from the struct;
  - opcode constants.
- One sub-module, `decode_comb`: a pure combinational instruction to {control word, illegal, is_ebreak} mapping. `decode_stage` owns the handshake, registers and FSM.

## Test plan
- Back-to-back stream `addi x1,x0,5` (0x00500093), `sub` (0x40208133), `out_ready` = 1:
  - `out_valid` 1 on consecutive cycles.
  - `alu_op` 0 then 1.
  - `arg2_sel` 1 then 0.
- Stream stall: `out_ready` = 0 for 3 cycles with `in_valid` = 1:
  - `in_ready` = 0 throughout.
  - `out_*` held stable.
  - No instruction lost or duplicated after release.
- Illegal inputs 0x00000000, 0x0000000F (fence) and 0x00000073 (ecall):
  - `out_illegal` = 1.
  - `out_ctrl` = 0.
- `ebreak` 0x00100073 with `DRAIN_CYCLES` = 4:
  - `in_ready` drops next cycle.
  - `halt` = 1 four cycles after accept and stays high until `rst`.
- `ebreak` accepted, `flush` two cycles later:
  - State returns to RUN.
  - `in_ready` = 1.
  - `halt` never rises.
- 0x02208133 (mul):
  - With `DECODE_RV32M_EN`: `alu_op` = 10, `out_illegal` = 0.
  - Without it: `out_illegal` = 1.
